score_display_mux: RTL

Parametrised successor to the game's single-digit score path. It keeps a multi-digit BCD score and a session high score, adds a configurable amount per eaten target, and saturates instead of wrapping. It also drives the board's multiplexed 7-segment display directly, with its own scan divider, leading-zero blanking and a score/high-score view select. It sits beside the snake control logic and consumes the same game-tick and target-reached strobes.

---
 rtl/score_display_mux.sv | 114 +++++++++++
 1 files changed

// File: rtl/score_display_mux.sv
// Multi-digit saturating BCD score with session high score, driving a
// multiplexed active-low 7-segment display with leading-zero blanking.
module score_display_mux #(
  parameter int DIGITS            = 4,
  parameter int SCAN_DIV          = 100000,
  parameter int POINTS_PER_TARGET = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  GAMECLOCK,
  input  logic                  REACHED_TARGET,
  input  logic                  CLEAR,
  input  logic                  SHOW_HIGH,
  output logic [4*DIGITS-1:0]   SCORE_OUT,
  output logic [4*DIGITS-1:0]   HIGH_OUT,
  output logic                  SATURATED,
  output logic [3:0]            SEG_SELECT,
  output logic [7:0]            HEX_OUT
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic          award;
  logic [W-1:0]  sum;
  logic [W-1:0]  next_score;
  logic          carry;
  logic [4:0]    dsum;

  logic [DW-1:0] div;
  logic          scan_tick;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic [W-1:0]  disp_val;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg;

  assign award     = GAMECLOCK & REACHED_TARGET;
  assign SATURATED = (SCORE_OUT == ALL_NINES);

  // Ripple BCD add; a carry out of the top digit means overflow, so saturate.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    dsum  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, SCORE_OUT[4*i +: 4]} + {4'b0, carry};
      if (i == 0) dsum = dsum + 5'(POINTS_PER_TARGET);
      if (dsum > 5'd9) begin
        sum[4*i +: 4] = 4'(dsum - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[4*i +: 4] = dsum[3:0];
        carry         = 1'b0;
      end
    end
    next_score = carry ? ALL_NINES : sum;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      SCORE_OUT <= '0;
      HIGH_OUT  <= '0;
    end else if (CLEAR) begin
      SCORE_OUT <= '0;
    end else if (award) begin
      SCORE_OUT <= next_score;
      // Packed BCD orders the same as its decimal value.
      if (next_score > HIGH_OUT) HIGH_OUT <= next_score;
    end
  end

  assign scan_tick = (div == DW'(SCAN_DIV - 1));
  assign next_idx  = (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
  assign disp_val  = SHOW_HIGH ? HIGH_OUT : SCORE_OUT;
  assign digit     = disp_val[{next_idx, 2'b00} +: 4];
  assign blank     = (next_idx != 2'd0) && ((disp_val >> {next_idx, 2'b00}) == '0);

  always_comb begin
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div        <= '0;
      idx        <= '0;
      SEG_SELECT <= '1;
      HEX_OUT    <= '1;
    end else if (scan_tick) begin
      div        <= '0;
      idx        <= next_idx;
      SEG_SELECT <= 4'b1111 & ~(4'b0001 << next_idx);
      HEX_OUT    <= {~(SHOW_HIGH && (next_idx == 2'(DIGITS - 1))),
                     blank ? 7'h7F : seg};
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule
